// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad column scanner: strobes one active-low column at a time, debounces
// a single pressed key, reports its code once per press and flags multi-key samples.
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int DIV_W           = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] keyboard,
  output logic [3:0] col_n,
  output logic [1:0] counter,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_key
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DEB_LAST   = DIV_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] CNT_ONE    = DIV_W'(1);

  state_t           state_q, state_d;
  logic [3:0]       sync1_q, rows_s_q;
  logic [3:0]       pat_q, pat_d;
  logic [DIV_W-1:0] dwell_q, dwell_d;
  logic [DIV_W-1:0] deb_q, deb_d;
  logic [1:0]       counter_q, counter_d;
  logic [3:0]       col_n_q, col_n_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;
  logic             multi_key_q, multi_key_d;

  function automatic logic single_low(input logic [3:0] rows);
    logic [3:0] act;
    act = ~rows;
    return (act != 4'd0) && ((act & (act - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] low_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    dwell_d     = dwell_q;
    deb_d       = deb_q;
    counter_d   = counter_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    multi_key_d = 1'b0;

    unique case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (rows_s_q == 4'hF) begin
            counter_d = counter_q + 2'd1;
          end else if (single_low(rows_s_q)) begin
            pat_d   = rows_s_q;
            deb_d   = '0;
            state_d = DEBOUNCE;
          end else begin
            multi_key_d = 1'b1;
            counter_d   = counter_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (rows_s_q == pat_q) begin
          if (deb_q == DEB_LAST) begin
            // {row, col} + 1 is exactly 4*row + col + 1, wrapping 16 to 0
            key_code_d  = {low_row(pat_q), counter_q} + 4'd1;
            key_valid_d = 1'b1;
            key_held_d  = 1'b1;
            deb_d       = '0;
            state_d     = HELD;
          end else begin
            deb_d = deb_q + CNT_ONE;
          end
        end else begin
          counter_d = counter_q + 2'd1;
          dwell_d   = '0;
          state_d   = SCAN;
        end
      end
      HELD: begin
        // Only an unbroken run of all-high samples counts toward release
        if (rows_s_q == 4'hF) begin
          if (deb_q == DEB_LAST) begin
            key_held_d = 1'b0;
            counter_d  = counter_q + 2'd1;
            dwell_d    = '0;
            deb_d      = '0;
            state_d    = SCAN;
          end else begin
            deb_d = deb_q + CNT_ONE;
          end
        end else begin
          deb_d = '0;
        end
      end
      default: state_d = SCAN;
    endcase

    col_n_d = ~(4'b0001 << counter_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      sync1_q     <= 4'hF;
      rows_s_q    <= 4'hF;
      pat_q       <= 4'hF;
      dwell_q     <= '0;
      deb_q       <= '0;
      counter_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      multi_key_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= keyboard;
      rows_s_q    <= sync1_q;
      pat_q       <= pat_d;
      dwell_q     <= dwell_d;
      deb_q       <= deb_d;
      counter_q   <= counter_d;
      col_n_q     <= col_n_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      multi_key_q <= multi_key_d;
    end
  end

  assign col_n     = col_n_q;
  assign counter   = counter_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;
  assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a matrix keypad model drives the rows from col_n and
// a cycle-level reference model predicts every output, plus directed press scenarios.
module tb_keypad_scan_ctrl;

  localparam int SD = 4;
  localparam int DB = 8;
  localparam int PH_SCAN = 0;
  localparam int PH_CONF = 1;
  localparam int PH_HOLD = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] keyboard;
  logic [3:0] col_n;
  logic [1:0] counter;
  logic [3:0] key_code;
  logic       key_valid, key_held, multi_key;

  logic [15:0] press   = 16'h0;
  logic        ovr_en  = 1'b0;
  logic [3:0]  ovr_val = 4'hF;

  int n_cmp = 0, n_fail = 0, n_valid = 0, n_multi = 0;

  logic [3:0] m_sync1, m_rows, m_latch, m_code;
  logic       m_valid, m_held, m_multi;
  int         m_phase, m_dwell, m_cnt, m_col;

  keypad_scan_ctrl #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB), .DIV_W(16)) dut (
    .clock(clock), .reset(reset), .keyboard(keyboard), .col_n(col_n),
    .counter(counter), .key_code(key_code), .key_valid(key_valid),
    .key_held(key_held), .multi_key(multi_key)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a pressed key pulls its row low only while its column is strobed
  always_comb begin
    keyboard = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press[r*4+c] && !col_n[c]) keyboard[r] = 1'b0;
    if (ovr_en) keyboard = ovr_val;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync1 = 4'hF; m_rows = 4'hF; m_latch = 4'hF; m_code = 4'h0;
    m_valid = 1'b0; m_held = 1'b0; m_multi = 1'b0;
    m_phase = PH_SCAN; m_dwell = 0; m_cnt = 0; m_col = 0;
  endtask

  task automatic model_step(input logic [3:0] kb);
    int zeros, r;
    zeros = 0; r = 0;
    for (int i = 0; i < 4; i++) if (!m_rows[i]) begin zeros++; r = i; end
    m_valid = 1'b0; m_multi = 1'b0;
    case (m_phase)
      PH_SCAN: begin
        if (m_dwell == SD - 1) begin
          m_dwell = 0;
          if (zeros == 1) begin
            m_latch = m_rows; m_phase = PH_CONF; m_cnt = 0;
          end else begin
            if (zeros > 1) m_multi = 1'b1;
            m_col = (m_col + 1) % 4;
          end
        end else m_dwell++;
      end
      PH_CONF: begin
        if (m_rows == m_latch) begin
          if (m_cnt == DB - 1) begin
            m_code = 4'((4*r + m_col + 1) % 16);
            m_valid = 1'b1; m_held = 1'b1; m_phase = PH_HOLD; m_cnt = 0;
          end else m_cnt++;
        end else begin
          m_phase = PH_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0;
        end
      end
      default: begin
        if (m_rows == 4'hF) begin
          if (m_cnt == DB - 1) begin
            m_held = 1'b0; m_col = (m_col + 1) % 4; m_dwell = 0; m_cnt = 0;
            m_phase = PH_SCAN;
          end else m_cnt++;
        end else m_cnt = 0;
      end
    endcase
    m_rows = m_sync1;
    m_sync1 = kb;
  endtask

  task automatic check_outputs();
    logic [3:0] ecol;
    ecol = ~(4'b0001 << m_col);
    chk("counter",   8'(counter),   8'(m_col));
    chk("col_n",     8'(col_n),     8'(ecol));
    chk("key_code",  8'(key_code),  8'(m_code));
    chk("key_valid", 8'(key_valid), 8'(m_valid));
    chk("key_held",  8'(key_held),  8'(m_held));
    chk("multi_key", 8'(multi_key), 8'(m_multi));
  endtask

  task automatic tick();
    logic [3:0] kb_cap;
    logic       rst_cap;
    @(negedge clock);
    kb_cap = keyboard; rst_cap = reset;
    @(posedge clock);
    #1;
    if (rst_cap) model_reset(); else model_step(kb_cap);
    if (key_valid === 1'b1) n_valid++;
    if (multi_key === 1'b1) n_multi++;
    check_outputs();
  endtask

  task automatic wait_valid(input string tag, input int max);
    int i;
    i = 0;
    while (key_valid !== 1'b1 && i < max) begin tick(); i++; end
    chk(tag, 8'(key_valid), 8'd1);
  endtask

  task automatic wait_held_fall(input string tag, input int max);
    int i;
    i = 0;
    while (key_held !== 1'b0 && i < max) begin tick(); i++; end
    chk(tag, 8'(key_held), 8'd0);
  endtask

  initial begin
    int v0, m0, r, c, i;
    model_reset();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // Idle scanning
    repeat (20) tick();
    chk("s1_no_valid", 8'(n_valid), 8'd0);

    // Clean press row1/col2, then release
    press = 16'h0; press[1*4+2] = 1'b1;
    wait_valid("s2_valid", 100);
    chk("s2_code", 8'(key_code), 8'h07);
    chk("s2_held", 8'(key_held), 8'd1);
    chk("s2_col", 8'(counter), 8'd2);
    v0 = n_valid;
    repeat (20) tick();
    chk("s2_single", 8'(n_valid), 8'(v0));
    press = 16'h0;
    wait_held_fall("s2_release", 100);
    chk("s2_resume_col", 8'(counter), 8'd3);

    // Glitch mid-debounce row3/col3
    v0 = n_valid;
    press[3*4+3] = 1'b1;
    i = 0;
    while (!(m_phase == PH_CONF && m_cnt == 3) && i < 200) begin tick(); i++; end
    chk("s3_reach_debounce", 8'(i < 200), 8'd1);
    ovr_en = 1'b1; ovr_val = 4'hF;
    repeat (3) tick();
    ovr_en = 1'b0;
    chk("s3_no_early", 8'(n_valid), 8'(v0));
    wait_valid("s3_valid", 200);
    chk("s3_code", 8'(key_code), 8'h00);
    repeat (10) tick();
    chk("s3_single", 8'(n_valid), 8'(v0 + 1));
    press = 16'h0;
    wait_held_fall("s3_release", 100);

    // Two rows low in col0
    v0 = n_valid; m0 = n_multi;
    press[0*4+0] = 1'b1; press[2*4+0] = 1'b1;
    repeat (40) tick();
    chk("s4_no_valid", 8'(n_valid), 8'(v0));
    chk("s4_multi_seen", 8'((n_multi - m0) >= 2 && (n_multi - m0) <= 3), 8'd1);
    chk("s4_code_kept", 8'(key_code), 8'h00);
    press = 16'h0;
    repeat (8) tick();

    // Reset in the middle of HELD on row2/col1
    press[2*4+1] = 1'b1;
    wait_valid("s5_valid", 200);
    chk("s5_code", 8'(key_code), 8'h0A);
    repeat (5) tick();
    chk("s5_held", 8'(key_held), 8'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("s5_rst_counter", 8'(counter), 8'd0);
    chk("s5_rst_col_n", 8'(col_n), 8'h0E);
    chk("s5_rst_code", 8'(key_code), 8'h00);
    chk("s5_rst_held", 8'(key_held), 8'd0);
    chk("s5_rst_valid", 8'(key_valid), 8'd0);
    repeat (2) tick();
    reset = 1'b0;
    v0 = n_valid;
    wait_valid("s5_revalid", 200);
    chk("s5_recode", 8'(key_code), 8'h0A);
    chk("s5_one_more", 8'(n_valid), 8'(v0 + 1));
    press = 16'h0;
    wait_held_fall("s5_release", 100);

    // Bouncy release of row0/col0
    press[0] = 1'b1;
    wait_valid("s6_valid", 200);
    chk("s6_code", 8'(key_code), 8'h01);
    v0 = n_valid;
    repeat (4) tick();
    press = 16'h0;
    repeat (2) tick();
    ovr_en = 1'b1; ovr_val = 4'b1110;
    repeat (2) tick();
    ovr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s6_still_held", 8'(key_held), 8'd1);
    end
    wait_held_fall("s6_release", 100);
    chk("s6_no_second", 8'(n_valid), 8'(v0));

    // Randomized presses, extra keys while held, and release noise
    for (int it = 0; it < 8; it++) begin
      r = int'($urandom_range(0, 3));
      c = int'($urandom_range(0, 3));
      press = 16'h0; press[r*4+c] = 1'b1;
      v0 = n_valid;
      wait_valid("rnd_valid", 200);
      chk("rnd_code", 8'(key_code), 8'((4*r + c + 1) % 16));
      repeat ($urandom_range(0, 20)) tick();
      if ($urandom_range(0, 1) == 1) press[$urandom_range(0, 15)] = 1'b1;
      repeat ($urandom_range(0, 20)) tick();
      chk("rnd_single", 8'(n_valid), 8'(v0 + 1));
      press = 16'h0;
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
        ovr_en = 1'b1; ovr_val = 4'($urandom);
        tick();
      end
      ovr_en = 1'b0;
      wait_held_fall("rnd_release", 200);
      repeat ($urandom_range(0, 10)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencer for the 4x4 matrix keypad path: drives the column strobe and the 2-bit column index consumed by the keypad encoder.
- Samples the active-low row lines, debounces a single key press and emits one registered key code per press.
- Flags multi-key conditions.
- Sits between the keypad pins and downstream hex display/entry logic.

Parameters:
- SCAN_DIV, 16, clock cycles each column is driven (dwell); minimum 4.
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required to accept a press or a release; minimum 2.
- DIV_W, 16, width of the dwell and debounce counters; must hold max(SCAN_DIV, DEBOUNCE_CYCLES).

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- keyboard  input  4  raw row lines, active-low, asynchronous to clock
- col_n  output  4  column drive, active-low one-hot: ~(1<<counter)
- counter  output  2  current column index, to the encoder
- key_code  output  4  code of last accepted key
- key_valid  output  1  one-cycle pulse when key_code updates
- key_held  output  1  high from acceptance until release is debounced
- multi_key  output  1  one-cycle pulse when more than one row is low at a sample point

Behaviour:
- Reset (async, active-high) values: state=SCAN; counter=0; col_n=4'b1110; key_code=0; key_valid=0; key_held=0; multi_key=0; all internal counters 0; synchronizer flops 4'b1111.
- Synchronizer: keyboard passes through a 2-flop synchronizer to give rows_s. Input-to-rows_s latency is 2 cycles. All decisions use rows_s only.
- Key code mapping, for row r (the index of the single low bit) and column c:
  - code = (4*r + c + 1) mod 16.
  - col0 gives 1,5,9,D; col1 gives 2,6,A,E; col2 gives 3,7,B,F; col3 gives 4,8,C,0.
- State SCAN:
  - dwell counts 0..SCAN_DIV-1 and then wraps.
  - When dwell==SCAN_DIV-1 (the sample point), rows_s is evaluated:
    - all ones: counter increments mod 4 (3 wraps to 0) and dwell clears.
    - exactly one zero: latch row pattern and counter, go to DEBOUNCE. counter/col_n stay frozen and the debounce count clears.
    - two or more zeros: multi_key pulses for 1 cycle, counter advances as if idle.
  - Rows are ignored at every point other than the sample point.
- State DEBOUNCE:
  - While rows_s equals the latched pattern, the debounce count increments.
  - On the cycle where the count equals DEBOUNCE_CYCLES-1 and rows still match, go to HELD. On that same transition key_code is registered and key_valid pulses for exactly 1 cycle; key_held is set.
  - Any mismatch returns to SCAN: counter advances by 1 and dwell clears. No key_valid.
- State HELD:
  - counter frozen.
  - The release count increments while rows_s==4'b1111 and clears on any other value, whether still pressed or bouncing.
  - When the release count reaches DEBOUNCE_CYCLES-1: key_held goes to 0, counter advances by 1, dwell clears, go to SCAN.
  - Additional keys pressed while HELD produce neither key_valid nor multi_key.
- col_n is always ~(1<<counter) and is registered together with counter, so they never disagree.
- key_code holds its value until the next accepted press; it is never cleared except by reset.
- key_valid and multi_key are never asserted in the same cycle.
- Reset asserted in any state takes effect immediately (async). On deassertion, scanning resumes from column 0 and a key held through reset is re-debounced and reported again.

Test Plan:
1. All benches use SCAN_DIV=4, DEBOUNCE_CYCLES=8, and a keypad model that pulls row r low only when col_n selects the pressed column.
   - Reset released, no key -> counter cycles 0,1,2,3,0 every 4 clocks; col_n cycles 1110,1101,1011,0111; key_valid stays 0.
2. Press row1/col2, hold clean -> counter freezes at 2; exactly one key_valid pulse with key_code=4'h7; key_held=1.
   - Release -> key_held falls 8 clocks after rows_s returns to 1111; scanning resumes at column 3.
3. Press row3/col3 with a 3-cycle glitch opening mid-debounce, then stable -> first attempt aborts with no pulse. Later acceptance gives key_code=4'h0 with a single key_valid.
4. Press row0 and row2 in col0 simultaneously -> multi_key pulses once per visit to col0; no key_valid; key_code unchanged from its previous value.
5. Hold row2/col1 (code 4'hA), then assert reset mid-HELD -> all outputs return to their reset values at once. After deassertion the key is rescanned and key_valid fires again with 4'hA.
6. Press row0/col0 (code 4'h1), release with bounce (1111, 1110, 1111 pattern within 8 cycles) -> key_held stays 1 until 8 consecutive all-high cycles. No second key_valid occurs during the bounce.
